// File: rtl/enc_ctrl.sv
// enc_ctrl: encoder filter reset/enable sequencing, x4 quadrature decode, index capture, fault latch.
// Optional build macro ENC_INDEX_CLEAR_EN: an armed index capture also zeroes the position.
module enc_ctrl #(
  parameter int POS_W      = 32,
  parameter int FLUSH_CYC  = 4,
  parameter int SETTLE_CYC = 4,
  parameter int ERR_LIMIT  = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_nrst,
  input  logic                    ctrl_en,
  input  logic                    filt_sel,
  input  logic                    home_arm,
  input  logic                    fault_clr,
  input  logic                    enc_a_f,
  input  logic                    enc_b_f,
  input  logic                    enc_z_f,
  output logic                    filter_nrst,
  output logic                    filter_en,
  output logic signed [POS_W-1:0] position,
  output logic signed [POS_W-1:0] index_pos,
  output logic                    index_valid,
  output logic                    dir,
  output logic [7:0]              err_cnt,
  output logic                    fault,
  output logic                    ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SETTLE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [15:0] FLUSH_LAST  = 16'(FLUSH_CYC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [7:0]  ERR_LIM     = 8'(ERR_LIMIT);

  state_t      state;
  logic [15:0] seq_cnt;
  logic [1:0]  prev_ab;
  logic        z_prev;
  logic        arm;

  logic [1:0]  cur_ab;
  logic [1:0]  dphase;
  logic        step_up;
  logic        step_dn;
  logic        step_bad;
  logic        z_rise;
  logic        reconfig;
  logic        capture;

  // Position of an AB pair along the A-leads-B cycle 00,10,11,01.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    cur_ab   = {enc_a_f, enc_b_f};
    dphase   = phase_of(cur_ab) - phase_of(prev_ab);
    step_up  = (dphase == 2'd1);
    step_dn  = (dphase == 2'd3);
    step_bad = (dphase == 2'd2);
    z_rise   = enc_z_f & ~z_prev;
    reconfig = (filt_sel != filter_en);
    capture  = (state == S_RUN) && ctrl_en && !reconfig && (err_cnt < ERR_LIM) && z_rise && arm;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      state       <= S_IDLE;
      seq_cnt     <= '0;
      prev_ab     <= '0;
      z_prev      <= 1'b0;
      arm         <= 1'b0;
      filter_nrst <= 1'b0;
      filter_en   <= 1'b0;
      position    <= '0;
      index_pos   <= '0;
      index_valid <= 1'b0;
      dir         <= 1'b0;
      err_cnt     <= '0;
      fault       <= 1'b0;
      ready       <= 1'b0;
    end else begin
      // AB and Z history run in every state so RUN entry starts from a fresh sample.
      prev_ab     <= cur_ab;
      z_prev      <= enc_z_f;
      arm         <= home_arm | (arm & ~capture);
      index_valid <= capture;
      if (!ctrl_en) begin
        state       <= S_IDLE;
        filter_nrst <= 1'b0;
        fault       <= 1'b0;
        ready       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state       <= S_FLUSH;
            seq_cnt     <= '0;
            filter_en   <= filt_sel;
            err_cnt     <= '0;
            filter_nrst <= 1'b0;
          end
          S_FLUSH: begin
            if (seq_cnt == FLUSH_LAST) begin
              state       <= S_SETTLE;
              seq_cnt     <= '0;
              filter_nrst <= 1'b1;
            end else begin
              seq_cnt <= seq_cnt + 16'd1;
            end
          end
          S_SETTLE: begin
            if (seq_cnt == SETTLE_LAST) begin
              state <= S_RUN;
              ready <= 1'b1;
            end else begin
              seq_cnt <= seq_cnt + 16'd1;
            end
          end
          S_RUN: begin
            if (reconfig) begin
              state       <= S_FLUSH;
              seq_cnt     <= '0;
              filter_en   <= filt_sel;
              err_cnt     <= '0;
              filter_nrst <= 1'b0;
              ready       <= 1'b0;
            end else if (err_cnt >= ERR_LIM) begin
              state <= S_FAULT;
              fault <= 1'b1;
              ready <= 1'b0;
            end else begin
              if (step_up) begin
                position <= position + POS_W'(1);
                dir      <= 1'b1;
              end else if (step_dn) begin
                position <= position - POS_W'(1);
                dir      <= 1'b0;
              end else if (step_bad) begin
                err_cnt <= sat_inc8(err_cnt);
              end
              if (capture) begin
                index_pos <= position;
`ifdef ENC_INDEX_CLEAR_EN
                position  <= '0;
`endif
              end
            end
          end
          S_FAULT: begin
            if (fault_clr) begin
              state       <= S_FLUSH;
              seq_cnt     <= '0;
              filter_en   <= filt_sel;
              err_cnt     <= '0;
              filter_nrst <= 1'b0;
              fault       <= 1'b0;
            end
          end
          default: begin
            state       <= S_IDLE;
            filter_nrst <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/enc_ctrl.md
Name: enc_ctrl

Overview:
Sequencing controller for the encoder input filter. It owns the filter's reset and enable lines and runs the flush/settle sequence whenever the filter is (re)configured. It decodes the filtered A/B/Z into a x4 quadrature position count with index capture. It tracks illegal transitions and enters a latched fault state. Sits between the encoder filter and the galvo motion loop.

Parameters:
POS_W, 32, position counter width (two's complement, wraps modulo 2^POS_W)
FLUSH_CYC, 4, cycles filter_nrst held low on (re)start, >=1
SETTLE_CYC, 4, cycles after flush before decoding starts; covers filter history plus output register
ERR_LIMIT, 16, illegal-transition count that forces FAULT, 1..255

Ports:
sys_clk  in  1  system clock
sys_nrst  in  1  synchronous active-low reset
ctrl_en  in  1  controller enable; low forces IDLE
filt_sel  in  1  requested filter mode (1 = filtered, 0 = bypass)
home_arm  in  1  one-cycle pulse; arms capture on next Z rising edge
fault_clr  in  1  one-cycle pulse; leaves FAULT
enc_a_f  in  1  filtered A from filter
enc_b_f  in  1  filtered B from filter
enc_z_f  in  1  filtered Z from filter
filter_nrst  out  1  filter reset, active low
filter_en  out  1  filter enable, equals filt_sel latched at FLUSH entry
position  out  POS_W  signed quadrature count
index_pos  out  POS_W  position captured at armed index
index_valid  out  1  one-cycle pulse when index_pos updates
dir  out  1  direction of last valid count (1 = up)
err_cnt  out  8  illegal transitions since last flush, saturating
fault  out  1  high in FAULT
ready  out  1  high in RUN

Behaviour:
- Reset (sys_nrst low at clock edge): state IDLE, filter_nrst=0, filter_en=0, position=0, index_pos=0, index_valid=0, dir=0, err_cnt=0, fault=0, ready=0, arm flag=0.
- States: IDLE, FLUSH, SETTLE, RUN, FAULT. The ctrl_en=0 condition takes priority from any state: go to IDLE next cycle. In IDLE, filter_nrst=0. position and index_pos are held, not cleared.
- IDLE -> FLUSH when ctrl_en=1. On FLUSH entry, latch filt_sel into filter_en and clear err_cnt.
- FLUSH: filter_nrst=0 for exactly FLUSH_CYC cycles, then go to SETTLE.
- SETTLE: filter_nrst=1 for exactly SETTLE_CYC cycles. On the last cycle, sample {enc_a_f,enc_b_f} as prev_ab, then go to RUN. No counting occurs before RUN.
- RUN: ready=1. If filt_sel differs from filter_en, go to FLUSH (reconfigure); no count is taken that cycle.
- Decode in RUN, each cycle, comparing prev_ab with cur_ab={a,b}, then prev_ab<=cur_ab:
  - Up step (+1, dir=1): 00->10->11->01->00 (A leads B).
  - Down step (-1, dir=0): the reverse sequence.
  - Unchanged: no action.
  - Illegal step (both bits change): no position change; err_cnt increments, saturating at 255. When err_cnt reaches ERR_LIMIT, go to FAULT next cycle.
- Position wraps modulo 2^POS_W with no saturation and no flag.
- Index:
  - home_arm sets the arm flag in any state.
  - In RUN, on a Z rising edge (registered z_prev=0, z=1) with the arm flag set: index_pos <= position value before this cycle's count, index_valid=1 for one cycle, arm flag cleared.
  - home_arm arriving in the same cycle as the Z edge does not capture; the flag stays set for the next edge.
  - Z edges outside RUN are ignored; z_prev is still tracked.
- FAULT: fault=1, ready=0, filter_nrst=1, counting stopped, position held. fault_clr goes to FLUSH. ctrl_en=0 goes to IDLE and clears fault.
- sys_nrst low mid-sequence: full reset on that edge. The filter is held in reset because filter_nrst=0.

Optional Feature:
ENC_INDEX_CLEAR_EN
- Defined: an armed index capture also sets position to 0 in the same cycle. The clear overrides that cycle's count step. index_pos still reports the pre-clear value.
- Undefined: index only captures; position is never altered by Z.

Test Plan:
- Reset, ctrl_en=1, filt_sel=1 -> filter_nrst low for 4 cycles, then high. ready rises at cycle 9 after ctrl_en. filter_en=1.
- In RUN, drive 8 full up cycles of AB (00,10,11,01), one state every 3 clocks -> position=32, dir=1. Then 3 down cycles -> position=20, dir=0.
- POS_W=8, start position 127, one up step -> position=128 (0x80, i.e. -128). Step down from 0 -> 0xFF.
- 16 illegal 00<->11 toggles -> err_cnt=16 and fault=1 the next cycle, position unchanged. fault_clr -> FLUSH, err_cnt=0, ready returns after 8 cycles.
- home_arm, then Z rise at position 37 -> index_valid pulse, index_pos=37. A second Z rise gives no pulse. With ENC_INDEX_CLEAR_EN: position=0 at that edge, even with a simultaneous up step.
- Toggle filt_sel 1->0 in RUN -> next cycle FLUSH, filter_en=0, position held. Deassert ctrl_en mid-SETTLE -> IDLE, filter_nrst=0.
